// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operand width, operation
// codes, FSM state encoding and operation classification helpers.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_PASSB  = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd11;
    localparam logic [4:0] OP_MULH   = 5'd12;
    localparam logic [4:0] OP_MULHSU = 5'd13;
    localparam logic [4:0] OP_MULHU  = 5'd14;
    localparam logic [4:0] OP_DIV    = 5'd15;
    localparam logic [4:0] OP_DIVU   = 5'd16;
    localparam logic [4:0] OP_REM    = 5'd17;
    localparam logic [4:0] OP_REMU   = 5'd18;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Operations that run through the iterative multiply/divide unit.
    function automatic logic is_multicycle(input logic [4:0] code);
        return (code >= OP_MUL) && (code <= OP_REMU);
    endfunction

    function automatic logic is_divide(input logic [4:0] code);
        return (code >= OP_DIV) && (code <= OP_REMU);
    endfunction

endpackage

// File: rtl/ex_alu_stage_if.sv
// ID/EX -> EX/MEM bus of the execute stage: instruction operands from the
// ID/EX register, stall back-pressure and the registered EX/MEM result.
interface ex_alu_stage_if;
    import alu_pkg::*;

    logic              in_valid;
    logic [4:0]        alu_ctrl_in;
    logic              alu_op2_sel_in;
    logic [DATA_W-1:0] op1_in;
    logic [DATA_W-1:0] op2_in;
    logic [DATA_W-1:0] sz_alu_in;
    logic              stall_out;
    logic [DATA_W-1:0] result_out;
    logic              zero_out;
    logic              valid_out;

    modport master (
        output in_valid, alu_ctrl_in, alu_op2_sel_in, op1_in, op2_in, sz_alu_in,
        input  stall_out, result_out, zero_out, valid_out
    );

    modport slave (
        input  in_valid, alu_ctrl_in, alu_op2_sel_in, op1_in, op2_in, sz_alu_in,
        output stall_out, result_out, zero_out, valid_out
    );

endinterface

// File: rtl/ex_alu_stage_mul_div.sv
// Iterative radix-2 multiply/divide unit. Works on operand magnitudes:
// shift-add multiply or restoring divide, one bit per cycle for 32 cycles,
// then applies the sign fix-up. done is high during the last iteration and
// result is valid combinationally in that cycle.
module mul_div_iter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              start,
    input  logic [4:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    logic                active;
    logic [4:0]          cnt;
    logic [4:0]          op_p0;
    logic                a_neg_p0;
    logic                b_neg_p0;
    logic                div_p0;
    logic                div_zero_p0;
    logic [DATA_W-1:0]   a_raw_p0;
    logic [DATA_W-1:0]   opnd_p0;
    logic [2*DATA_W-1:0] acc_p0;

    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W-1:0]   rem_diff;
    logic [2*DATA_W-1:0] acc_next;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;

    function automatic logic [DATA_W-1:0] negate_if(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] negate_wide_if(input logic neg, input logic [2*DATA_W-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Only the signed interpretations of each operand contribute a sign.
    assign a_neg = a[DATA_W-1] && ((op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                                   (op == OP_DIV) || (op == OP_REM));
    assign b_neg = b[DATA_W-1] && ((op == OP_MUL) || (op == OP_MULH) ||
                                   (op == OP_DIV) || (op == OP_REM));
    assign a_mag = negate_if(a_neg, a);
    assign b_mag = negate_if(b_neg, b);

    assign done = active && (cnt == 5'd31);

    // Control: run flag and iteration counter; abort and reset drop back to idle.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            active <= 1'b0;
            cnt    <= 5'd0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= 5'd0;
        end else if (active) begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31)
                active <= 1'b0;
        end
    end

    // ---- stage p0: operand latch at start, accumulator update per iteration
    // Multiply keeps {product_hi, multiplier} in acc; divide keeps {remainder, quotient}.
    always_ff @(posedge clk) begin
        if (start) begin
            op_p0       <= op;
            a_neg_p0    <= a_neg;
            b_neg_p0    <= b_neg;
            div_p0      <= is_divide(op);
            div_zero_p0 <= (b == '0);
            a_raw_p0    <= a;
            opnd_p0     <= is_divide(op) ? b_mag : a_mag;
            acc_p0      <= {{DATA_W{1'b0}}, (is_divide(op) ? a_mag : b_mag)};
        end else if (active) begin
            acc_p0 <= acc_next;
        end
    end

    // One radix-2 step of the selected algorithm.
    always_comb begin
        mul_sum  = {1'b0, acc_p0[2*DATA_W-1:DATA_W]} + (acc_p0[0] ? {1'b0, opnd_p0} : '0);
        rem_sh   = {acc_p0[2*DATA_W-1:DATA_W], acc_p0[DATA_W-1]};
        rem_diff = rem_sh[DATA_W-1:0] - opnd_p0;
        acc_next = {mul_sum, acc_p0[DATA_W-1:1]};
        if (div_p0) begin
            if (rem_sh >= {1'b0, opnd_p0})
                acc_next = {rem_diff, acc_p0[DATA_W-2:0], 1'b1};
            else
                acc_next = {rem_sh[DATA_W-1:0], acc_p0[DATA_W-2:0], 1'b0};
        end
    end

    // Sign fix-up and result selection from the final iteration's value.
    always_comb begin
        prod = negate_wide_if(a_neg_p0 ^ b_neg_p0, acc_next);
        quot = acc_next[DATA_W-1:0];
        rem  = acc_next[2*DATA_W-1:DATA_W];
        case (op_p0)
            OP_MUL:                        result = prod[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[2*DATA_W-1:DATA_W];
            OP_DIV:   result = div_zero_p0 ? '1 : negate_if(a_neg_p0 ^ b_neg_p0, quot);
            OP_DIVU:  result = quot;
            OP_REM:   result = div_zero_p0 ? a_raw_p0 : negate_if(a_neg_p0, rem);
            OP_REMU:  result = rem;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: single-cycle ALU plus an IDLE/BUSY controller that hands
// multiply/divide operations to the iterative unit and stalls upstream
// until its result is ready. Results land in the EX/MEM output register.
module ex_alu_stage
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    ex_alu_stage_if.slave bus
);

    state_e                    state;
    state_e                    state_next;
    logic                      stall;
    logic                      start;
    logic                      mc_op;
    logic                      md_done;
    logic        [DATA_W-1:0]  md_result;
    logic        [DATA_W-1:0]  op_b;
    logic signed [DATA_W-1:0]  a_s;
    logic signed [DATA_W-1:0]  b_s;
    logic        [DATA_W-1:0]  alu_res;
    logic        [DATA_W-1:0]  result_p1;
    logic                      zero_p1;
    logic                      vld_p1;

    assign op_b  = bus.alu_op2_sel_in ? bus.sz_alu_in : bus.op2_in;
    assign a_s   = $signed(bus.op1_in);
    assign b_s   = $signed(op_b);
    assign mc_op = is_multicycle(bus.alu_ctrl_in);

    mul_div_iter u_mul_div (
        .clk    (clk),
        .rst    (rst),
        .abort  (flush),
        .start  (start),
        .op     (bus.alu_ctrl_in),
        .a      (bus.op1_in),
        .b      (op_b),
        .done   (md_done),
        .result (md_result)
    );

    // Single-cycle operations; multi-cycle and reserved codes yield zero here.
    always_comb begin
        alu_res = '0;
        case (bus.alu_ctrl_in)
            OP_ADD:   alu_res = bus.op1_in + op_b;
            OP_SUB:   alu_res = bus.op1_in - op_b;
            OP_SLL:   alu_res = bus.op1_in << op_b[4:0];
            OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            OP_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, (bus.op1_in < op_b)};
            OP_XOR:   alu_res = bus.op1_in ^ op_b;
            OP_SRL:   alu_res = bus.op1_in >> op_b[4:0];
            OP_SRA:   alu_res = $unsigned(a_s >>> op_b[4:0]);
            OP_OR:    alu_res = bus.op1_in | op_b;
            OP_AND:   alu_res = bus.op1_in & op_b;
            OP_PASSB: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    // Next state, stall and start; reset and flush override everything.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid && mc_op) begin
                    stall      = 1'b1;
                    start      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = !md_done;
                if (md_done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst || flush) begin
            stall      = 1'b0;
            start      = 1'b0;
            state_next = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // ---- stage p1: EX/MEM result register
    // Reset and flush both clear it; otherwise capture single-cycle results in
    // IDLE or the iterative result on its final cycle, holding data otherwise.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            result_p1 <= '0;
            zero_p1   <= 1'b1;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid && !mc_op) begin
                        result_p1 <= alu_res;
                        zero_p1   <= (alu_res == '0);
                        vld_p1    <= 1'b1;
                    end
                end
                BUSY: begin
                    if (md_done) begin
                        result_p1 <= md_result;
                        zero_p1   <= (md_result == '0);
                        vld_p1    <= 1'b1;
                    end
                end
                default: vld_p1 <= 1'b0;
            endcase
        end
    end

    assign bus.stall_out  = stall;
    assign bus.result_out = result_p1;
    assign bus.zero_out   = zero_p1;
    assign bus.valid_out  = vld_p1;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_ex_alu_stage;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    ex_alu_stage_if bus ();

    ex_alu_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference results straight from the operation definitions.
    function automatic logic [31:0] ref_result(input logic [4:0] code, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, ub, p;
        longint unsigned pu;
        int              ia, ib, sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        ia = a;
        ib = b;
        sh = int'(b & 32'h1F);
        case (code)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << sh;
            5'd3:  return (ia < ib) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> sh;
            5'd7:  return ia >>> sh;
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            5'd11: begin p = sa * sb; return p[31:0]; end
            5'd12: begin p = sa * sb; return p[63:32]; end
            5'd13: begin p = sa * ub; return p[63:32]; end
            5'd14: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
            5'd15: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            5'd16: return (b == 0) ? 32'hFFFFFFFF : a / b;
            5'd17: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return ia % ib;
            end
            5'd18: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    // Present one instruction, follow it to its result and check timing,
    // stall behaviour, data, zero flag, the one-cycle valid and result hold.
    task automatic run_op(input string name, input logic [4:0] code, input logic [31:0] a,
                          input logic [31:0] op2, input logic [31:0] sz, input logic sel);
        logic [31:0] b, exp;
        int          lat_exp, stall_exp, cycles, stalls;
        logic        mc, seen;
        b         = sel ? sz : op2;
        exp       = ref_result(code, a, b);
        mc        = (code >= 5'd11) && (code <= 5'd18);
        lat_exp   = mc ? 33 : 1;
        stall_exp = mc ? 32 : 0;
        @(negedge clk);
        bus.alu_ctrl_in    = code;
        bus.op1_in         = a;
        bus.op2_in         = op2;
        bus.sz_alu_in      = sz;
        bus.alu_op2_sel_in = sel;
        bus.in_valid       = 1'b1;
        cycles = 0;
        stalls = 0;
        seen   = 1'b0;
        while (!seen && cycles < 40) begin
            #1;
            if (bus.stall_out) stalls++;
            @(posedge clk);
            #1;
            cycles++;
            if (bus.valid_out) begin
                seen = 1'b1;
            end else if (mc) begin
                bus.op1_in    = $urandom;
                bus.op2_in    = $urandom;
                bus.sz_alu_in = $urandom;
            end
        end
        bus.in_valid = 1'b0;
        check({name, ":latency"}, cycles, lat_exp);
        check({name, ":stall_cycles"}, stalls, stall_exp);
        check({name, ":result"}, bus.result_out, exp);
        check({name, ":zero"}, 32'(bus.zero_out), 32'(exp == 0));
        @(posedge clk);
        #1;
        check({name, ":valid_drop"}, 32'(bus.valid_out), 32'd0);
        check({name, ":hold"}, bus.result_out, exp);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [6];
        edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFF9};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        flush              = 1'b0;
        bus.in_valid       = 1'b1;
        bus.alu_ctrl_in    = 5'd11;
        bus.alu_op2_sel_in = 1'b0;
        bus.op1_in         = 32'd3;
        bus.op2_in         = 32'd4;
        bus.sz_alu_in      = 32'd0;

        // Reset state, with a multi-cycle op pending to prove stall is masked.
        repeat (2) @(posedge clk);
        #1;
        check("reset:result", bus.result_out, 32'h0);
        check("reset:zero", 32'(bus.zero_out), 32'd1);
        check("reset:valid", 32'(bus.valid_out), 32'd0);
        check("reset:stall", 32'(bus.stall_out), 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;

        run_op("add_ovf", 5'd0,  32'h7FFFFFFF, $urandom, 32'h1, 1'b1);
        run_op("sra4",    5'd7,  32'h80000000, 32'h24, $urandom, 1'b0);
        run_op("rsvd",    5'd25, 32'h12345678, 32'h9, $urandom, 1'b0);
        run_op("mulhu",   5'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, $urandom, 1'b0);
        run_op("div_ovf", 5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0);
        run_op("rem_z",   5'd17, 32'd7, 32'd0, 32'h5, 1'b0);
        run_op("divu_z",  5'd16, 32'd5, 32'd0, 32'h5, 1'b0);

        // Flush a DIV -7/2 while its counter sits at 10.
        @(negedge clk);
        bus.alu_ctrl_in    = 5'd15;
        bus.op1_in         = 32'hFFFFFFF9;
        bus.op2_in         = 32'd2;
        bus.alu_op2_sel_in = 1'b0;
        bus.in_valid       = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("flush:stall_during", 32'(bus.stall_out), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush:valid", 32'(bus.valid_out), 32'd0);
        check("flush:result", bus.result_out, 32'h0);
        check("flush:zero", 32'(bus.zero_out), 32'd1);
        check("flush:stall_after", 32'(bus.stall_out), 32'd0);
        run_op("add_after_flush", 5'd0, 32'd1, 32'd1, $urandom, 1'b0);

        // Reset in the middle of a REMU.
        @(negedge clk);
        bus.alu_ctrl_in = 5'd18;
        bus.op1_in      = 32'd100;
        bus.op2_in      = 32'd7;
        bus.in_valid    = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("rst_busy:stall_during", 32'(bus.stall_out), 32'd0);
        @(posedge clk);
        #1;
        check("rst_busy:result", bus.result_out, 32'h0);
        check("rst_busy:zero", 32'(bus.zero_out), 32'd1);
        check("rst_busy:valid", 32'(bus.valid_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("sub_after_rst", 5'd1, 32'd5, 32'd5, $urandom, 1'b0);

        // Randomized operations over the whole code space.
        for (int i = 0; i < 60; i++) begin
            run_op("rand", 5'($urandom_range(0, 31)), pick_operand(), pick_operand(),
                   pick_operand(), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
